// File: rtl/mux_arb_pkg.sv
// Shared constants for the two-requester mux arbiter: state encoding and counter sizing.
package mux_arb_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] G0   = 2'b01;
   localparam logic [1:0] G1   = 2'b10;

   // Tenure counter width; never narrower than one bit.
   function automatic int cnt_w(input int max_hold);
      return (max_hold > 2) ? $clog2(max_hold) : 1;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/data/grant bundle between requesters and the arbiter; master = requester side.
interface mux_arbiter_if #(
   parameter int DATA_W = 1
);
   logic [1:0]        req;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] y;
   logic [1:0]        grant;
   logic              sel;
   logic              busy;
   logic [DATA_W-1:0] m;

   modport master (output req, x, y, input grant, sel, busy, m);
   modport slave  (input req, x, y, output grant, sel, busy, m);
endinterface

// File: rtl/mux2to1_w.sv
// DATA_W-bit 2:1 mux, purely combinational (s=0 -> x, s=1 -> y).
module mux2to1_w #(
   parameter int DATA_W = 1
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              s,
   output logic [DATA_W-1:0] m
);
   assign m = s ? y : x;
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of a shared 2:1 mux; grant/sel/busy one cycle after req, m zero-latency.
// Holder keeps the mux until it drops req or hits MAX_HOLD cycles while the other waits.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic          clock,
   input  logic          reset,
   mux_arbiter_if.slave  bus
);

   localparam int                CNT_W   = cnt_w(MAX_HOLD);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ptr_q, ptr_d;
   logic              sel_q, sel_d;
   logic [1:0]        grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] mux_m;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            unique case (bus.req)
               2'b01:   state_d = G0;
               2'b10:   state_d = G1;
               2'b11:   state_d = ptr_q ? G0 : G1;
               default: state_d = IDLE;
            endcase
         end
         G0: begin
            if (!bus.req[0] || (cnt_q == CNT_MAX && bus.req[1])) begin
               ptr_d   = 1'b0;
               cnt_d   = '0;
               state_d = bus.req[1] ? G1 : IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         G1: begin
            if (!bus.req[1] || (cnt_q == CNT_MAX && bus.req[0])) begin
               ptr_d   = 1'b1;
               cnt_d   = '0;
               state_d = bus.req[0] ? G0 : IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are encoded from the next state so they register alongside it.
      sel_d   = sel_q;
      grant_d = 2'b00;
      if (state_d == G0) begin
         sel_d   = 1'b0;
         grant_d = 2'b01;
      end else if (state_d == G1) begin
         sel_d   = 1'b1;
         grant_d = 2'b10;
      end
      busy_d = |grant_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 1'b1;
         sel_q   <= 1'b0;
         grant_q <= 2'b00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

   mux2to1_w #(.DATA_W(DATA_W)) u_mux (
      .x (bus.x),
      .y (bus.y),
      .s (sel_q),
      .m (mux_m)
   );

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.busy  = busy_q;
   assign bus.m     = busy_q ? mux_m : '0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (DATA_W=1, MAX_HOLD=4): vector table, corner sequences, random vs model.
module tb_mux_arbiter;

   localparam int MAX_HOLD = 4;

   logic clock;
   logic reset;

   mux_arbiter_if #(.DATA_W(1)) bus ();

   mux_arbiter #(.DATA_W(1), .MAX_HOLD(MAX_HOLD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model: who owns the mux, how many cycles it has held it, who was served last.
   int owner;
   int held;
   int last;
   int msel;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic [1:0] r);
      int other;
      if (rst) begin
         owner = -1; held = 0; last = 1; msel = 0;
      end else if (owner < 0) begin
         if (r == 2'b01)      owner = 0;
         else if (r == 2'b10) owner = 1;
         else if (r == 2'b11) owner = 1 - last;
         held = 1;
      end else begin
         other = 1 - owner;
         if (!r[owner] || (held >= MAX_HOLD && r[other])) begin
            last = owner;
            if (r[other]) begin
               owner = other;
               held  = 1;
            end else begin
               owner = -1;
            end
         end else if (held < MAX_HOLD) begin
            held++;
         end
      end
      if (owner >= 0) msel = owner;
   endtask

   function automatic int exp_grant();
      return (owner < 0) ? 0 : (1 << owner);
   endfunction

   function automatic int exp_m();
      if (owner < 0) return 0;
      return (msel != 0) ? int'(bus.y) : int'(bus.x);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " grant"}, int'(bus.grant), exp_grant());
      chk({tag, " sel"},   int'(bus.sel),   msel);
      chk({tag, " busy"},  int'(bus.busy),  (owner >= 0) ? 1 : 0);
      chk({tag, " m"},     int'(bus.m),     exp_m());
      chk({tag, " grant_not_11"}, (bus.grant == 2'b11) ? 1 : 0, 0);
   endtask

   // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
   task automatic cycle(input logic rst, input logic [1:0] r, input logic xv, input logic yv,
                        input string tag);
      reset   = rst;
      bus.req = r;
      bus.x   = xv;
      bus.y   = yv;
      @(posedge clock);
      model_step(rst, r);
      @(negedge clock);
      check_model(tag);
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic       x;
      logic       y;
      logic [1:0] g;
      logic       s;
      logic       b;
      logic       m;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic x, input logic y,
                               input logic [1:0] g, input logic s, input logic b, input logic m);
      vec_t v;
      v.rst = rst; v.req = req; v.x = x; v.y = y;
      v.g = g; v.s = s; v.b = b; v.m = m;
      return v;
   endfunction

   initial begin
      reset   = 1'b1;
      bus.req = 2'b00;
      bus.x   = 1'b0;
      bus.y   = 1'b0;
      owner = -1; held = 0; last = 1; msel = 0;
      @(negedge clock);

      // Reset with contention, single requester grant/release, round-robin under full contention.
      vecs.push_back(mk(1, 2'b11, 1, 1, 2'b00, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11, 1, 1, 2'b00, 0, 0, 0));
      vecs.push_back(mk(0, 2'b01, 1, 0, 2'b01, 0, 1, 1));
      vecs.push_back(mk(0, 2'b00, 1, 0, 2'b00, 0, 0, 0));
      vecs.push_back(mk(1, 2'b00, 1, 0, 2'b00, 0, 0, 0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 2'b11, 1, 0, 2'b01, 0, 1, 1));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 2'b11, 1, 0, 2'b10, 1, 1, 0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 2'b11, 1, 0, 2'b01, 0, 1, 1));

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].req, vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_grant", i), int'(bus.grant), int'(vecs[i].g));
         chk($sformatf("vec%0d tbl_sel", i),   int'(bus.sel),   int'(vecs[i].s));
         chk($sformatf("vec%0d tbl_busy", i),  int'(bus.busy),  int'(vecs[i].b));
         chk($sformatf("vec%0d tbl_m", i),     int'(bus.m),     int'(vecs[i].m));
      end

      // Lone requester 1 is never preempted.
      cycle(1, 2'b00, 0, 0, "solo_rst");
      for (int i = 0; i < 20; i++) begin
         cycle(0, 2'b10, 0, 1, $sformatf("solo%0d", i));
         chk($sformatf("solo%0d hold_grant", i), int'(bus.grant), 2);
         chk($sformatf("solo%0d hold_sel", i),   int'(bus.sel),   1);
      end

      // Same-edge swap from G0 at cnt=1; fresh tenure in G1 then lasts MAX_HOLD cycles.
      cycle(1, 2'b00, 0, 0, "swap_rst");
      cycle(0, 2'b01, 1, 0, "swap_a");
      cycle(0, 2'b01, 1, 0, "swap_b");
      cycle(0, 2'b10, 1, 0, "swap_c");
      chk("swap handover", int'(bus.grant), 2);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 2'b11, 1, 0, $sformatf("swap_hold%0d", i));
         chk($sformatf("swap_hold%0d grant", i), int'(bus.grant), 2);
      end
      cycle(0, 2'b11, 1, 0, "swap_back");
      chk("swap back to 0", int'(bus.grant), 1);

      // Reset during G1 overrides contention; afterwards requester 0 wins the tie.
      cycle(1, 2'b00, 0, 0, "mr_rst");
      cycle(0, 2'b10, 0, 1, "mr_g1");
      cycle(0, 2'b11, 0, 1, "mr_g1b");
      chk("mr in G1", int'(bus.grant), 2);
      cycle(1, 2'b11, 0, 1, "mr_reset");
      chk("mr reset grant", int'(bus.grant), 0);
      cycle(0, 2'b11, 1, 1, "mr_after");
      chk("mr after grant", int'(bus.grant), 1);

      // Random traffic against the model, plus combinational data changes within a cycle.
      for (int i = 0; i < 400; i++) begin
         logic rr;
         rr = ($urandom_range(0, 49) == 0);
         cycle(rr, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
         bus.x = ~bus.x;
         bus.y = 1'($urandom);
         #1;
         chk($sformatf("rnd%0d m_comb", i), int'(bus.m), exp_m());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
